// File: rtl/gip_ext_bus_pkg.sv
// rtl/gip_ext_bus_pkg.sv - shared types and helpers for the GIP external bus master
package gip_ext_bus_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } bus_state_t;

  // Chip-select index to one-hot chip enable; also used by the top-level address decoder.
  function automatic logic [3:0] cs_decode(input logic [1:0] cs);
    return 4'b0001 << cs;
  endfunction

endpackage

// File: rtl/gip_ext_bus_master.sv
// rtl/gip_ext_bus_master.sv - setup/strobe/hold sequencer for asynchronous external bus chips
module gip_ext_bus_master
  import gip_ext_bus_pkg::*;
#(
  parameter int SETUP_CYCLES      = 1,
  parameter int STROBE_CYCLES     = 3,
  parameter int HOLD_CYCLES       = 1,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic        int_clock,
  input  logic        int_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_cs,
  input  logic [23:0] req_address,
  input  logic [31:0] req_write_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_read_data,
  output logic [3:0]  ext_bus_ce,
  output logic        ext_bus_oe,
  output logic        ext_bus_we,
  output logic [23:0] ext_bus_address,
  output logic [31:0] ext_bus_write_data,
  output logic        ext_bus_write_data_enable,
  input  logic [31:0] ext_bus_read_data
);

  localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURNAROUND_CYCLES - 1);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_q;
  logic [1:0]       cs_q;
  logic [23:0]      addr_q;
  logic [31:0]      data_q;

  logic             accept, capture, done;
  logic             wr_n;
  logic [1:0]       cs_n;
  logic [23:0]      addr_n;
  logic [31:0]      data_n;
  logic             active;

  logic             ready_d, rsp_valid_d, oe_d, we_d, wde_d;
  logic [3:0]       ce_d;
  logic [23:0]      addr_d;
  logic [31:0]      wdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - 1'b1;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if (SETUP_CYCLES > 0) begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
          end else begin
            state_d = ST_STROBE;
            cnt_d   = STROBE_LOAD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = STROBE_LOAD;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          capture = ~wr_q;
          if (HOLD_CYCLES > 0) begin
            state_d = ST_HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) done = 1'b1;
      end
      ST_TURN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (done) begin
      if (!wr_q && TURNAROUND_CYCLES > 0) begin
        state_d = ST_TURN;
        cnt_d   = TURN_LOAD;
      end else begin
        state_d = ST_IDLE;
      end
    end

    // Outputs are registered from the state being entered, so accept-time fields come from the request.
    wr_n   = accept ? req_write      : wr_q;
    cs_n   = accept ? req_cs         : cs_q;
    addr_n = accept ? req_address    : addr_q;
    data_n = accept ? req_write_data : data_q;
    active = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);

    ready_d     = (state_d == ST_IDLE);
    rsp_valid_d = done;
    ce_d        = active ? cs_decode(cs_n) : 4'b0000;
    addr_d      = active ? addr_n : 24'h0;
    wde_d       = active & wr_n;
    wdata_d     = (active & wr_n) ? data_n : 32'h0;
    oe_d        = (state_d == ST_STROBE) & ~wr_n;
    we_d        = (state_d == ST_STROBE) & wr_n;
  end

  always_ff @(posedge int_clock) begin
    if (int_reset) begin
      state_q                   <= ST_IDLE;
      cnt_q                     <= '0;
      wr_q                      <= 1'b0;
      cs_q                      <= 2'd0;
      addr_q                    <= 24'h0;
      data_q                    <= 32'h0;
      req_ready                 <= 1'b1;
      rsp_valid                 <= 1'b0;
      rsp_read_data             <= 32'h0;
      ext_bus_ce                <= 4'b0000;
      ext_bus_oe                <= 1'b0;
      ext_bus_we                <= 1'b0;
      ext_bus_address           <= 24'h0;
      ext_bus_write_data        <= 32'h0;
      ext_bus_write_data_enable <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q   <= req_write;
        cs_q   <= req_cs;
        addr_q <= req_address;
        data_q <= req_write_data;
      end
      if (capture) rsp_read_data <= ext_bus_read_data;
      req_ready                 <= ready_d;
      rsp_valid                 <= rsp_valid_d;
      ext_bus_ce                <= ce_d;
      ext_bus_oe                <= oe_d;
      ext_bus_we                <= we_d;
      ext_bus_address           <= addr_d;
      ext_bus_write_data        <= wdata_d;
      ext_bus_write_data_enable <= wde_d;
    end
  end

endmodule

// File: tb/tb_gip_ext_bus_master.sv
// tb/tb_gip_ext_bus_master.sv - directed self-checking bench for gip_ext_bus_master
module tb_gip_ext_bus_master;

  logic clk = 1'b0;
  logic int_reset = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // default-parameter instance
  logic        d_valid = 0, d_ready, d_write = 0, d_rsp, d_oe, d_we, d_wde;
  logic [1:0]  d_cs = 0;
  logic [23:0] d_addr_in = 0, d_addr;
  logic [31:0] d_wdata_in = 0, d_rdata, d_wdata, d_pin;
  logic [3:0]  d_ce;
  int          oe_run = 0;

  // strobe-only instance
  logic        f_valid = 0, f_ready, f_write = 0, f_rsp, f_oe, f_we, f_wde;
  logic [1:0]  f_cs = 0;
  logic [23:0] f_addr_in = 0, f_addr;
  logic [31:0] f_wdata_in = 0, f_rdata, f_wdata;
  logic [3:0]  f_ce;

  // long-turnaround instance
  logic        t_valid = 0, t_ready, t_write = 0, t_rsp, t_oe, t_we, t_wde;
  logic [1:0]  t_cs = 0;
  logic [23:0] t_addr_in = 0, t_addr;
  logic [31:0] t_wdata_in = 0, t_rdata, t_wdata;
  logic [3:0]  t_ce;

  // bus model: data valid only in the third consecutive oe cycle
  assign d_pin = (d_oe && oe_run == 2) ? 32'hCAFEF00D : 32'h0;
  always @(posedge clk) oe_run <= d_oe ? oe_run + 1 : 0;

  gip_ext_bus_master u_def (
    .int_clock(clk), .int_reset(int_reset), .req_valid(d_valid), .req_ready(d_ready),
    .req_write(d_write), .req_cs(d_cs), .req_address(d_addr_in), .req_write_data(d_wdata_in),
    .rsp_valid(d_rsp), .rsp_read_data(d_rdata), .ext_bus_ce(d_ce), .ext_bus_oe(d_oe),
    .ext_bus_we(d_we), .ext_bus_address(d_addr), .ext_bus_write_data(d_wdata),
    .ext_bus_write_data_enable(d_wde), .ext_bus_read_data(d_pin));

  gip_ext_bus_master #(.SETUP_CYCLES(0), .STROBE_CYCLES(1), .HOLD_CYCLES(0), .TURNAROUND_CYCLES(0)) u_fast (
    .int_clock(clk), .int_reset(int_reset), .req_valid(f_valid), .req_ready(f_ready),
    .req_write(f_write), .req_cs(f_cs), .req_address(f_addr_in), .req_write_data(f_wdata_in),
    .rsp_valid(f_rsp), .rsp_read_data(f_rdata), .ext_bus_ce(f_ce), .ext_bus_oe(f_oe),
    .ext_bus_we(f_we), .ext_bus_address(f_addr), .ext_bus_write_data(f_wdata),
    .ext_bus_write_data_enable(f_wde), .ext_bus_read_data(32'h0));

  gip_ext_bus_master #(.TURNAROUND_CYCLES(3)) u_ta (
    .int_clock(clk), .int_reset(int_reset), .req_valid(t_valid), .req_ready(t_ready),
    .req_write(t_write), .req_cs(t_cs), .req_address(t_addr_in), .req_write_data(t_wdata_in),
    .rsp_valid(t_rsp), .rsp_read_data(t_rdata), .ext_bus_ce(t_ce), .ext_bus_oe(t_oe),
    .ext_bus_we(t_we), .ext_bus_address(t_addr), .ext_bus_write_data(t_wdata),
    .ext_bus_write_data_enable(t_wde), .ext_bus_read_data(32'h12345678));

  // protocol invariants on the default instance
  logic chk_en = 0;
  int   n_rsp = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      tests = tests + 4;
      if ($countones(d_ce) > 1) begin fails++; $display("FAIL inv_onehot ce=%b required at most one bit", d_ce); end
      if (d_oe && d_we) begin fails++; $display("FAIL inv_oe_we oe=%b we=%b required not both", d_oe, d_we); end
      if (d_we && !d_wde) begin fails++; $display("FAIL inv_we_wde we=%b wde=%b required wde with we", d_we, d_wde); end
      if (d_ce == 4'b0 && (d_addr != 0 || d_wdata != 0)) begin
        fails++; $display("FAIL inv_idle_bus addr=%h wdata=%h required 0 with ce=0", d_addr, d_wdata);
      end
      if (d_rsp) n_rsp++;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    int_reset = 0;
    @(negedge clk);
    tests = tests + 8;
    if (d_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b required 1", d_ready); end
    if (d_rsp !== 1'b0) begin fails++; $display("FAIL reset_rsp got %b required 0", d_rsp); end
    if (d_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h required 0", d_rdata); end
    if ({d_ce, d_oe, d_we, d_wde} !== 7'b0) begin fails++; $display("FAIL reset_strobes got %b required 0", {d_ce, d_oe, d_we, d_wde}); end
    if ({d_addr, d_wdata} !== 56'h0) begin fails++; $display("FAIL reset_bus got %h required 0", {d_addr, d_wdata}); end
    if (f_ready !== 1'b1) begin fails++; $display("FAIL reset_f_ready got %b required 1", f_ready); end
    if (t_ready !== 1'b1) begin fails++; $display("FAIL reset_t_ready got %b required 1", t_ready); end
    if (t_ce !== 4'b0) begin fails++; $display("FAIL reset_t_ce got %b required 0", t_ce); end
  endtask

  task automatic test_write();
    logic e_act;
    d_valid = 1; d_write = 1; d_cs = 2; d_addr_in = 24'h000123; d_wdata_in = 32'hDEADBEEF;
    @(negedge clk);
    d_valid = 0; d_addr_in = 0; d_wdata_in = 0;
    for (int k = 1; k <= 7; k++) begin
      e_act = (k >= 1 && k <= 5);
      tests = tests + 7;
      if (d_ce !== (e_act ? 4'b0100 : 4'b0000)) begin fails++; $display("FAIL wr_ce k=%0d got %b required %b", k, d_ce, e_act ? 4'b0100 : 4'b0000); end
      if (d_we !== (k >= 2 && k <= 4)) begin fails++; $display("FAIL wr_we k=%0d got %b", k, d_we); end
      if (d_oe !== 1'b0) begin fails++; $display("FAIL wr_oe k=%0d got %b required 0", k, d_oe); end
      if (d_wde !== e_act) begin fails++; $display("FAIL wr_wde k=%0d got %b required %b", k, d_wde, e_act); end
      if (d_addr !== (e_act ? 24'h000123 : 24'h0)) begin fails++; $display("FAIL wr_addr k=%0d got %h", k, d_addr); end
      if (d_wdata !== (e_act ? 32'hDEADBEEF : 32'h0)) begin fails++; $display("FAIL wr_data k=%0d got %h", k, d_wdata); end
      if ({d_rsp, d_ready} !== {k == 6, k >= 6}) begin fails++; $display("FAIL wr_rsp_ready k=%0d got %b required %b", k, {d_rsp, d_ready}, {k == 6, k >= 6}); end
      @(negedge clk);
    end
  endtask

  task automatic test_read();
    logic e_act;
    d_valid = 1; d_write = 0; d_cs = 0; d_addr_in = 24'h000456;
    @(negedge clk);
    d_valid = 0;
    for (int k = 1; k <= 7; k++) begin
      e_act = (k >= 1 && k <= 5);
      tests = tests + 5;
      if (d_ce !== (e_act ? 4'b0001 : 4'b0000)) begin fails++; $display("FAIL rd_ce k=%0d got %b", k, d_ce); end
      if (d_oe !== (k >= 2 && k <= 4)) begin fails++; $display("FAIL rd_oe k=%0d got %b", k, d_oe); end
      if ({d_we, d_wde} !== 2'b00) begin fails++; $display("FAIL rd_we_wde k=%0d got %b required 00", k, {d_we, d_wde}); end
      if (d_rsp !== (k == 6)) begin fails++; $display("FAIL rd_rsp k=%0d got %b required %b", k, d_rsp, k == 6); end
      if (d_ready !== (k == 7)) begin fails++; $display("FAIL rd_ready k=%0d got %b required %b", k, d_ready, k == 7); end
      if (k == 6) begin
        tests++;
        if (d_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL rd_data got %h required cafef00d", d_rdata); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    logic acc;
    f_valid = 1; f_write = 1; f_cs = 1; f_addr_in = 24'h10; f_wdata_in = 32'h100;
    for (int k = 0; k < 10; k++) begin
      tests = tests + 4;
      if (f_ready !== ((k % 2 == 0) || k >= 6)) begin fails++; $display("FAIL b2b_ready k=%0d got %b", k, f_ready); end
      if (f_ce !== ((k == 1 || k == 3 || k == 5) ? 4'b0010 : 4'b0000)) begin fails++; $display("FAIL b2b_ce k=%0d got %b", k, f_ce); end
      if (f_we !== (k == 1 || k == 3 || k == 5)) begin fails++; $display("FAIL b2b_we k=%0d got %b", k, f_we); end
      if (f_rsp !== (k == 2 || k == 4 || k == 6)) begin fails++; $display("FAIL b2b_rsp k=%0d got %b", k, f_rsp); end
      if (k == 1 || k == 3 || k == 5) begin
        tests++;
        if (f_addr !== 24'(24'h10 + (k / 2))) begin fails++; $display("FAIL b2b_addr k=%0d got %h required %h", k, f_addr, 24'h10 + (k / 2)); end
      end
      acc = f_valid && f_ready;
      @(negedge clk);
      if (acc) begin
        n_acc++;
        if (n_acc == 3) f_valid = 0;
        else begin f_addr_in = 24'(24'h10 + n_acc); f_wdata_in = 32'(32'h100 + n_acc); end
      end
    end
    tests++;
    if (n_acc != 3) begin fails++; $display("FAIL b2b_accepts got %0d required 3", n_acc); end
  endtask

  task automatic test_turnaround();
    int first_wde = -1;
    logic acc;
    t_valid = 1; t_write = 0; t_cs = 3; t_addr_in = 24'h0000AA;
    @(negedge clk);
    t_write = 1; t_addr_in = 24'h0000BB; t_wdata_in = 32'h55;
    for (int k = 1; k <= 16; k++) begin
      if (t_wde && first_wde < 0) first_wde = k;
      if (k <= 9) begin
        tests++;
        if (t_ready !== (k == 9)) begin fails++; $display("FAIL ta_ready k=%0d got %b required %b", k, t_ready, k == 9); end
      end
      if (k <= 5) begin
        tests++;
        if (t_ce !== 4'b1000 || t_wde !== 1'b0) begin fails++; $display("FAIL ta_read_phase k=%0d ce=%b wde=%b", k, t_ce, t_wde); end
      end
      acc = t_valid && t_ready;
      @(negedge clk);
      if (acc) t_valid = 0;
    end
    tests++;
    if (first_wde != 10) begin fails++; $display("FAIL ta_first_wde got cycle %0d required 10", first_wde); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    d_valid = 1; d_write = 1; d_cs = 1; d_addr_in = 24'h000777; d_wdata_in = 32'h11112222;
    @(negedge clk);
    d_valid = 0;
    repeat (2) @(negedge clk);
    int_reset = 1;
    d_valid = 1; d_write = 1; d_cs = 3; d_addr_in = 24'h000999;
    @(negedge clk);
    int_reset = 0;
    d_valid = 0;
    tests = tests + 3;
    if ({d_ce, d_oe, d_we, d_wde} !== 7'b0) begin fails++; $display("FAIL rst_mid_strobes got %b required 0", {d_ce, d_oe, d_we, d_wde}); end
    if ({d_addr, d_wdata} !== 56'h0) begin fails++; $display("FAIL rst_mid_bus got %h required 0", {d_addr, d_wdata}); end
    if (d_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got %b required 1", d_ready); end
    for (int k = 0; k < 10; k++) begin
      if (d_rsp || d_ce != 4'b0) bad++;
      @(negedge clk);
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rst_mid_quiet got %0d active cycles required 0", bad); end
  endtask

  task automatic test_random();
    int n_req = 0;
    int n_wait;
    n_rsp = 0;
    chk_en = 1;
    for (int i = 0; i < 1000; i++) begin
      d_valid = 1;
      d_write = 1'($urandom_range(0, 1));
      d_cs = 2'($urandom_range(0, 3));
      d_addr_in = 24'($urandom);
      d_wdata_in = $urandom;
      n_wait = 0;
      while (!d_ready && n_wait < 50) begin @(negedge clk); n_wait++; end
      if (n_wait >= 50) begin
        tests++; fails++;
        $display("FAIL rand_timeout req=%0d ready stuck at %b", i, d_ready);
        d_valid = 0;
        break;
      end
      @(negedge clk);
      n_req++;
      d_valid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    chk_en = 0;
    tests++;
    if (n_rsp != n_req) begin fails++; $display("FAIL rand_counts rsp=%0d required %0d", n_rsp, n_req); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_turnaround();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
